// File: rtl/dly_code_ctrl.sv
// DLL delay-line calibration controller: averages phase-detector votes per window and
// steps a saturating tap code with lock detection. Optional fast acquisition: DLY_CODE_CTRL_FAST_ACQ_EN.
module dly_code_ctrl #(
    parameter int unsigned CODE_W     = 6,
    parameter int unsigned INIT_CODE  = 32,
    parameter int unsigned SETTLE_CYC = 8,
    parameter int unsigned AVG_N      = 16,
    parameter int unsigned LOCK_WIN   = 4
) (
    input  logic              CLK,
    input  logic              RSTN,
    input  logic              EN,
    input  logic              PD_EARLY,
    input  logic              PD_LATE,
    output logic [CODE_W-1:0] DLY_CODE,
    output logic              LOCK,
    output logic              BUSY,
    output logic              SAT
);

    localparam int unsigned ACC_W   = $clog2(AVG_N) + 2;
    localparam int unsigned LCK_W   = $clog2(LOCK_WIN + 1);
    localparam int unsigned CNT_MAX = (SETTLE_CYC > AVG_N) ? SETTLE_CYC : AVG_N;
    localparam int unsigned CNT_W   = $clog2(CNT_MAX);

    localparam logic [CODE_W-1:0]       CODE_MAX    = '1;
    localparam logic [CODE_W-1:0]       CODE_INIT   = CODE_W'(INIT_CODE);
    localparam logic [CNT_W-1:0]        SETTLE_LAST = CNT_W'(SETTLE_CYC - 1);
    localparam logic [CNT_W-1:0]        WIN_LAST    = CNT_W'(AVG_N - 1);
    localparam logic signed [ACC_W-1:0] THR         = ACC_W'(AVG_N / 2);
    localparam logic [LCK_W-1:0]        LOCK_MAX    = LCK_W'(LOCK_WIN);
`ifdef DLY_CODE_CTRL_FAST_ACQ_EN
    localparam logic [CNT_W-1:0]        FAST_LAST   = CNT_W'(AVG_N / 4 - 1);
    localparam logic signed [ACC_W-1:0] FAST_THR    = ACC_W'((AVG_N / 8 > 0) ? AVG_N / 8 : 1);
`endif

    typedef enum logic [1:0] {IDLE, SETTLE, SAMPLE, UPDATE} state_t;
    typedef enum logic [1:0] {DIR_NONE, DIR_UP, DIR_DN} dir_t;

    state_t                    state_q;
    dir_t                      dir_q;
    logic [CNT_W-1:0]          cnt_q;
    logic signed [ACC_W-1:0]   acc_q;
    logic [CODE_W-1:0]         code_q;
    logic [LCK_W-1:0]          lcnt_q;
    logic                      lock_q;
    logic                      busy_q;
    logic                      sat_q;
`ifdef DLY_CODE_CTRL_FAST_ACQ_EN
    logic                      fast_q;
    logic                      fast_end;
`endif

    logic [CNT_W-1:0]          win_last;
    logic signed [ACC_W-1:0]   thr;
    logic signed [ACC_W-1:0]   acc_inc;
    logic signed [ACC_W-1:0]   acc_d;
    logic [CODE_W-1:0]         step;
    logic [CODE_W:0]           up_sum;
    logic [CODE_W-1:0]         code_d;
    logic [LCK_W-1:0]          lcnt_d;
    logic                      vote_up;
    logic                      vote_dn;
    logic                      sat_hit;
    logic                      quiet;
    dir_t                      step_dir;
    dir_t                      dir_d;

    always_comb begin
        win_last = WIN_LAST;
        thr      = THR;
        step     = CODE_W'(1);
`ifdef DLY_CODE_CTRL_FAST_ACQ_EN
        fast_end = 1'b0;
        if (fast_q) begin
            win_last = FAST_LAST;
            thr      = FAST_THR;
            step     = CODE_W'(4);
        end
`endif
        acc_inc = '0;
        if (PD_EARLY && !PD_LATE) begin
            acc_inc = ACC_W'(1);
        end else if (PD_LATE && !PD_EARLY) begin
            acc_inc = '1;
        end
        acc_d = acc_q + acc_inc;

        vote_up  = (acc_q >= thr);
        vote_dn  = (acc_q <= -thr);
        sat_hit  = (vote_up && code_q == CODE_MAX) || (vote_dn && code_q == '0);
        step_dir = DIR_NONE;
        code_d   = code_q;
        up_sum   = {1'b0, code_q} + {1'b0, step};
        if (vote_up && code_q != CODE_MAX) begin
            step_dir = DIR_UP;
            code_d   = (up_sum > {1'b0, CODE_MAX}) ? CODE_MAX : up_sum[CODE_W-1:0];
        end else if (vote_dn && code_q != '0) begin
            step_dir = DIR_DN;
            code_d   = (code_q < step) ? '0 : code_q - step;
        end

        // A blocked step is treated as a hold; a reversal is dither and also counts as quiet.
        quiet  = (step_dir == DIR_NONE) || (dir_q != DIR_NONE && step_dir != dir_q);
        lcnt_d = quiet ? ((lcnt_q == LOCK_MAX) ? lcnt_q : lcnt_q + 1'b1) : '0;
        dir_d  = (step_dir == DIR_NONE) ? dir_q : step_dir;
`ifdef DLY_CODE_CTRL_FAST_ACQ_EN
        if (fast_q) begin
            lcnt_d   = '0;
            fast_end = (step_dir != DIR_NONE) && (dir_q != DIR_NONE) && (step_dir != dir_q);
        end
`endif
    end

    always_ff @(posedge CLK or negedge RSTN) begin
        if (!RSTN) begin
            state_q <= IDLE;
            dir_q   <= DIR_NONE;
            cnt_q   <= '0;
            acc_q   <= '0;
            code_q  <= CODE_INIT;
            lcnt_q  <= '0;
            lock_q  <= 1'b0;
            busy_q  <= 1'b0;
            sat_q   <= 1'b0;
`ifdef DLY_CODE_CTRL_FAST_ACQ_EN
            fast_q  <= 1'b0;
`endif
        end else if (!EN) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            acc_q   <= '0;
            lock_q  <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    state_q <= SETTLE;
                    dir_q   <= DIR_NONE;
                    cnt_q   <= '0;
                    acc_q   <= '0;
                    code_q  <= CODE_INIT;
                    lcnt_q  <= '0;
                    lock_q  <= 1'b0;
                    sat_q   <= 1'b0;
                    busy_q  <= 1'b1;
`ifdef DLY_CODE_CTRL_FAST_ACQ_EN
                    fast_q  <= 1'b1;
`endif
                end
                SETTLE: begin
                    if (cnt_q == SETTLE_LAST) begin
                        cnt_q   <= '0;
                        state_q <= SAMPLE;
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                SAMPLE: begin
                    acc_q <= acc_d;
                    if (cnt_q == win_last) begin
                        cnt_q   <= '0;
                        state_q <= UPDATE;
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                UPDATE: begin
                    code_q  <= code_d;
                    sat_q   <= sat_q | sat_hit;
                    lcnt_q  <= lcnt_d;
                    lock_q  <= (lcnt_d == LOCK_MAX);
                    dir_q   <= dir_d;
                    acc_q   <= '0;
                    state_q <= SETTLE;
`ifdef DLY_CODE_CTRL_FAST_ACQ_EN
                    if (fast_end) begin
                        fast_q <= 1'b0;
                    end
`endif
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign DLY_CODE = code_q;
    assign LOCK     = lock_q;
    assign BUSY     = busy_q;
    assign SAT      = sat_q;

endmodule

// File: tb/tb_dly_code_ctrl.sv
// Scoreboard bench for dly_code_ctrl (default build): stimulus queues expected outputs
// tagged with a cycle number; the monitor compares them on the falling edge.
module tb_dly_code_ctrl;

    logic       CLK = 1'b0;
    logic       RSTN, EN, PD_EARLY, PD_LATE;
    logic [5:0] DLY_CODE;
    logic       LOCK, BUSY, SAT;

    dly_code_ctrl #(
        .CODE_W    (6),
        .INIT_CODE (32),
        .SETTLE_CYC(8),
        .AVG_N     (16),
        .LOCK_WIN  (4)
    ) dut (
        .CLK     (CLK),
        .RSTN    (RSTN),
        .EN      (EN),
        .PD_EARLY(PD_EARLY),
        .PD_LATE (PD_LATE),
        .DLY_CODE(DLY_CODE),
        .LOCK    (LOCK),
        .BUSY    (BUSY),
        .SAT     (SAT)
    );

    always #5 CLK = ~CLK;

    int cyc = 0;
    always @(posedge CLK) cyc <= cyc + 1;

    typedef struct {
        int         cyc;
        string      name;
        logic [8:0] v;
    } exp_t;

    exp_t sb[$];
    exp_t mon_e;
    int   total = 0;
    int   bad   = 0;

    int   last_code = 32;
    bit   last_lock = 1'b0;
    bit   last_sat  = 1'b0;

    task automatic expect_now(input string nm, input int code, input bit lock, input bit busy, input bit sat);
        exp_t e;
        e.cyc  = cyc;
        e.name = nm;
        e.v    = {6'(code), lock, busy, sat};
        sb.push_back(e);
    endtask

    always @(negedge CLK) begin
        while (sb.size() > 0 && sb[0].cyc <= cyc) begin
            mon_e = sb.pop_front();
            total++;
            if (mon_e.cyc != cyc) begin
                bad++;
                $display("FAIL %s: check for cycle %0d not taken (now %0d)", mon_e.name, mon_e.cyc, cyc);
            end else if ({DLY_CODE, LOCK, BUSY, SAT} !== mon_e.v) begin
                bad++;
                $display("FAIL %s cyc=%0d: got code=%0d lock=%b busy=%b sat=%b, want code=%0d lock=%b busy=%b sat=%b",
                         mon_e.name, cyc, DLY_CODE, LOCK, BUSY, SAT,
                         mon_e.v[8:3], mon_e.v[2], mon_e.v[1], mon_e.v[0]);
            end
        end
    end

    task automatic enable(input string nm);
        EN = 1'b1;
        @(posedge CLK); #1;
        last_code = 32;
        last_lock = 1'b0;
        last_sat  = 1'b0;
        expect_now(nm, 32, 1'b0, 1'b1, 1'b0);
    endtask

    task automatic disable_en(input string nm);
        EN = 1'b0; PD_EARLY = 1'b0; PD_LATE = 1'b0;
        @(posedge CLK); #1;
        last_lock = 1'b0;
        expect_now(nm, last_code, 1'b0, 1'b0, last_sat);
    endtask

    // One full loop iteration: 8 settle cycles (PD driven with junk), 16 samples, 1 update.
    task automatic window(input string nm, input logic [15:0] e, input logic [15:0] l,
                          input int code, input bit lock, input bit sat);
        for (int i = 0; i < 25; i++) begin
            if (i >= 8 && i < 24) begin
                PD_EARLY = e[i-8];
                PD_LATE  = l[i-8];
            end else begin
                PD_EARLY = 1'b1;
                PD_LATE  = 1'b0;
            end
            @(posedge CLK); #1;
            if (i == 23) expect_now({nm, "_pre"}, last_code, last_lock, 1'b1, last_sat);
        end
        expect_now(nm, code, lock, 1'b1, sat);
        last_code = code;
        last_lock = lock;
        last_sat  = sat;
    endtask

    // Runs settle plus n early-only samples of a window without finishing it.
    task automatic partial(input int n);
        PD_EARLY = 1'b1; PD_LATE = 1'b0;
        for (int i = 0; i < 8 + n; i++) begin
            @(posedge CLK); #1;
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        RSTN = 1'b0; EN = 1'b0; PD_EARLY = 1'b0; PD_LATE = 1'b0;
        repeat (3) @(posedge CLK); #1;
        expect_now("reset", 32, 1'b0, 1'b0, 1'b0);
        RSTN = 1'b1;
        repeat (6) @(posedge CLK); #1;
        expect_now("idle_en0", 32, 1'b0, 1'b0, 1'b0);

        // Constant EARLY: climb to 63 one step per window, then saturate.
        enable("enable_a");
        for (int k = 1; k <= 31; k++) window("up", 16'hFFFF, 16'h0000, 32 + k, 1'b0, 1'b0);
        window("sat_top", 16'hFFFF, 16'h0000, 63, 1'b0, 1'b1);
        disable_en("dis_a");
        repeat (3) @(posedge CLK); #1;
        expect_now("dis_a_hold", 63, 1'b0, 1'b0, 1'b1);

        // Alternating windows dither 32/33 and lock; two EARLY windows in a row unlock.
        enable("enable_b");
        window("alt1", 16'hFFFF, 16'h0000, 33, 1'b0, 1'b0);
        window("alt2", 16'h0000, 16'hFFFF, 32, 1'b0, 1'b0);
        window("alt3", 16'hFFFF, 16'h0000, 33, 1'b0, 1'b0);
        window("alt4", 16'h0000, 16'hFFFF, 32, 1'b0, 1'b0);
        window("alt5", 16'hFFFF, 16'h0000, 33, 1'b1, 1'b0);
        window("alt6", 16'h0000, 16'hFFFF, 32, 1'b1, 1'b0);
        window("alt7", 16'hFFFF, 16'h0000, 33, 1'b1, 1'b0);
        window("alt8", 16'hFFFF, 16'h0000, 34, 1'b0, 1'b0);
        disable_en("dis_b");

        // Balanced PD votes hold; four holds lock; both-high holds too.
        enable("enable_c");
        window("mix1", 16'h00FF, 16'hFF00, 32, 1'b0, 1'b0);
        window("mix2", 16'h5555, 16'hAAAA, 32, 1'b0, 1'b0);
        window("mix3", 16'h0F0F, 16'hF0F0, 32, 1'b0, 1'b0);
        window("mix4", 16'h00FF, 16'hFF00, 32, 1'b1, 1'b0);
        window("both", 16'hFFFF, 16'hFFFF, 32, 1'b1, 1'b0);

        // EN drop after 5 samples discards the window.
        partial(5);
        disable_en("en_drop");
        enable("enable_d");
        window("hold7e", 16'h007F, 16'h0000, 32, 1'b0, 1'b0);
        window("thr_up8", 16'h00FF, 16'h0000, 33, 1'b0, 1'b0);
        window("hold7l", 16'h0000, 16'h007F, 33, 1'b0, 1'b0);
        window("thr_dn8", 16'h0000, 16'h00FF, 32, 1'b0, 1'b0);
        window("up_again", 16'h00FF, 16'h0000, 33, 1'b0, 1'b0);

        // Async reset mid-sample.
        partial(6);
        RSTN = 1'b0;
        #1;
        expect_now("rst_mid", 32, 1'b0, 1'b0, 1'b0);
        EN = 1'b0;
        @(posedge CLK); #1;
        expect_now("rst_held", 32, 1'b0, 1'b0, 1'b0);
        RSTN = 1'b1;

        repeat (3) @(posedge CLK);
        @(negedge CLK); #1;
        while (sb.size() > 0) begin
            mon_e = sb.pop_front();
            total++;
            bad++;
            $display("FAIL %s: expectation never checked", mon_e.name);
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
